// File: rtl/id_ex_decode_stage_if.sv
// ID/EX decode stage bus: upstream instruction handshake, flush, ID/EX register outputs.
// Latency: none, this is wiring only.
// Backpressure: in_ready/out_ready valid-ready pairs; the master side drives in_* and out_ready.
// Ports: in_valid/in_ready/in_instr/in_pc/flush from IF/ID; out_* ID/EX register contents
// with out_valid/out_ready to EX; hazard_stall and stall_count for observability.
interface id_ex_decode_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [XLEN-1:0]  in_pc;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_pc;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic [4:0]       out_rd;
  logic             out_RUWr;
  logic [2:0]       out_ImmSrc;
  logic             out_AluASrc;
  logic             out_AluBSrc;
  logic [4:0]       out_BrOp;
  logic [4:0]       out_ALUOp;
  logic             out_DMWr;
  logic [2:0]       out_DMCtrl;
  logic [1:0]       out_RUDataWrSrc;
  logic             out_is_load;
  logic             out_illegal;
  logic             hazard_stall;
  logic [CNT_W-1:0] stall_count;

  // master: the surrounding pipeline (IF/ID producer and EX consumer)
  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_RUWr, out_ImmSrc,
           out_AluASrc, out_AluBSrc, out_BrOp, out_ALUOp, out_DMWr, out_DMCtrl,
           out_RUDataWrSrc, out_is_load, out_illegal, hazard_stall, stall_count
  );

  // slave: the decode stage itself
  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_RUWr, out_ImmSrc,
           out_AluASrc, out_AluBSrc, out_BrOp, out_ALUOp, out_DMWr, out_DMCtrl,
           out_RUDataWrSrc, out_is_load, out_illegal, hazard_stall, stall_count
  );
endinterface

// File: rtl/id_ex_decode_stage.sv
// RV32I(+M) decode into the ID/EX pipeline register with load-use stall and stall counter.
// Latency: 1 cycle from acceptance to out_valid.
// Backpressure: in_ready drops on flush, load-use hazard, or a full register not drained by EX.
// Ports: clk, rst (sync, active-high), bus (id_ex_decode_stage_if.slave) carrying all
// handshake, instruction and control-bundle signals.
module id_ex_decode_stage #(
  parameter int XLEN      = 32,
  parameter int EN_M_EXT  = 0,
  parameter int EN_HAZARD = 1,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  id_ex_decode_stage_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            ruwr;
    logic [2:0]      immsrc;
    logic            alua;
    logic            alub;
    logic [4:0]      brop;
    logic [4:0]      aluop;
    logic            dmwr;
    logic [2:0]      dmctrl;
    logic [1:0]      wrsrc;
    logic            is_load;
    logic            illegal;
  } idex_t;

  localparam bit M_ON  = (EN_M_EXT != 0);
  localparam bit HZ_ON = (EN_HAZARD != 0);

  idex_t            dec;
  idex_t            q;
  logic             valid_q;
  logic             use_rs1;
  logic             use_rs2;
  logic             ill;
  logic             hazard;
  logic             stall;
  logic             rdy;
  logic [CNT_W-1:0] cnt_q;

  wire [6:0] opcode = bus.in_instr[6:0];
  wire [2:0] f3     = bus.in_instr[14:12];
  wire [6:0] f7     = bus.in_instr[31:25];

  always_comb begin
    dec     = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    ill     = 1'b0;
    dec.pc  = bus.in_pc;
    dec.rs1 = bus.in_instr[19:15];
    dec.rs2 = bus.in_instr[24:20];
    dec.rd  = bus.in_instr[11:7];
    case (opcode)
      7'b0110011: begin // R-type
        dec.ruwr = 1'b1;
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
        if (f7 == 7'b0000000)                                        dec.aluop = {2'b00, f3};
        else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) dec.aluop = {2'b01, f3};
        else if (f7 == 7'b0000001 && M_ON)                           dec.aluop = {2'b10, f3};
        else                                                         ill = 1'b1;
      end
      7'b0010011: begin // I-arith; only the shifts carry a funct7
        dec.ruwr = 1'b1;
        dec.alub = 1'b1;
        use_rs1  = 1'b1;
        if (f3 == 3'b001) begin
          if (f7 == 7'b0000000) dec.aluop = 5'b00001;
          else                  ill = 1'b1;
        end else if (f3 == 3'b101) begin
          if (f7 == 7'b0000000)      dec.aluop = 5'b00101;
          else if (f7 == 7'b0100000) dec.aluop = 5'b01101;
          else                       ill = 1'b1;
        end else begin
          dec.aluop = {2'b00, f3};
        end
      end
      7'b0000011: begin // load
        dec.ruwr    = 1'b1;
        dec.alub    = 1'b1;
        dec.wrsrc   = 2'b01;
        dec.is_load = 1'b1;
        dec.dmctrl  = f3;
        use_rs1     = 1'b1;
        ill         = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      7'b1100111: begin // JALR
        dec.ruwr  = 1'b1;
        dec.alub  = 1'b1;
        dec.brop  = 5'b10000;
        dec.wrsrc = 2'b10;
        use_rs1   = 1'b1;
      end
      7'b1100011: begin // branch
        dec.immsrc = 3'b101;
        dec.alua   = 1'b1;
        dec.alub   = 1'b1;
        dec.brop   = {2'b01, f3};
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        ill        = (f3 == 3'b010) || (f3 == 3'b011);
      end
      7'b0100011: begin // store
        dec.immsrc = 3'b001;
        dec.alub   = 1'b1;
        dec.dmwr   = 1'b1;
        dec.dmctrl = f3;
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        ill        = (f3 > 3'b010);
      end
      7'b1101111: begin // JAL
        dec.ruwr   = 1'b1;
        dec.immsrc = 3'b110;
        dec.alua   = 1'b1;
        dec.alub   = 1'b1;
        dec.brop   = 5'b10000;
        dec.wrsrc  = 2'b10;
      end
      7'b0110111: begin // LUI: ALU passes operand B through
        dec.ruwr   = 1'b1;
        dec.immsrc = 3'b010;
        dec.alub   = 1'b1;
        dec.aluop  = 5'b01001;
      end
      7'b0010111: begin // AUIPC
        dec.ruwr   = 1'b1;
        dec.immsrc = 3'b010;
        dec.alua   = 1'b1;
        dec.alub   = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    // An illegal instruction must not change architectural state or redirect fetch.
    if (ill) begin
      dec.ruwr = 1'b0;
      dec.dmwr = 1'b0;
      dec.brop = 5'b00000;
    end
    dec.illegal = ill;
  end

  // Load-use: the load still sitting in ID/EX produces a register the incoming instruction reads.
  assign hazard = HZ_ON && valid_q && q.is_load && (q.rd != 5'd0) && bus.in_valid &&
                  ((use_rs1 && dec.rs1 == q.rd) || (use_rs2 && dec.rs2 == q.rd));
  assign stall  = hazard && !bus.flush;
  assign rdy    = !bus.flush && !stall && (!valid_q || bus.out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      q       <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (bus.in_valid && rdy) begin
      valid_q <= 1'b1;
      q       <= dec;
    end else if (bus.out_ready) begin
      // During a stall with EX draining, this empties the register: the bubble.
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                  cnt_q <= '0;
    else if (stall && cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
  end

  assign bus.in_ready        = rdy;
  assign bus.hazard_stall    = stall;
  assign bus.stall_count     = cnt_q;
  assign bus.out_valid       = valid_q;
  assign bus.out_pc          = q.pc;
  assign bus.out_rs1         = q.rs1;
  assign bus.out_rs2         = q.rs2;
  assign bus.out_rd          = q.rd;
  assign bus.out_RUWr        = q.ruwr;
  assign bus.out_ImmSrc      = q.immsrc;
  assign bus.out_AluASrc     = q.alua;
  assign bus.out_AluBSrc     = q.alub;
  assign bus.out_BrOp        = q.brop;
  assign bus.out_ALUOp       = q.aluop;
  assign bus.out_DMWr        = q.dmwr;
  assign bus.out_DMCtrl      = q.dmctrl;
  assign bus.out_RUDataWrSrc = q.wrsrc;
  assign bus.out_is_load     = q.is_load;
  assign bus.out_illegal     = q.illegal;

endmodule

// File: tb/tb_id_ex_decode_stage.sv
// Directed bench for id_ex_decode_stage: two instances, A (M on, hazard on, 2-bit counter)
// and B (M off, hazard off, 16-bit counter), each driven through its own interface.
module tb_id_ex_decode_stage;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [31:0] I_ADD  = 32'h002081B3; // add x3,x1,x2
  localparam logic [31:0] I_SUB  = 32'h402081B3; // sub x3,x1,x2
  localparam logic [31:0] I_LW   = 32'h0000A283; // lw x5,0(x1)
  localparam logic [31:0] I_DEP  = 32'h00028333; // add x6,x5,x0
  localparam logic [31:0] I_MUL  = 32'h022081B3; // mul x3,x1,x2

  always #5 clk = ~clk;

  id_ex_decode_stage_if #(.XLEN(32), .CNT_W(2))  ia ();
  id_ex_decode_stage_if #(.XLEN(32), .CNT_W(16)) ib ();

  id_ex_decode_stage #(.XLEN(32), .EN_M_EXT(1), .EN_HAZARD(1), .CNT_W(2)) dut_a (
    .clk(clk), .rst(rst), .bus(ia)
  );
  id_ex_decode_stage #(.XLEN(32), .EN_M_EXT(0), .EN_HAZARD(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .bus(ib)
  );

  // Control vector: {RUWr,ImmSrc,AluASrc,AluBSrc,BrOp,ALUOp,DMWr,DMCtrl,RUDataWrSrc,is_load,illegal}
  function automatic logic [23:0] mk(input logic ruwr, input logic [2:0] imm, input logic a,
                                     input logic b, input logic [4:0] br, input logic [4:0] alu,
                                     input logic dmwr, input logic [2:0] dmc, input logic [1:0] src,
                                     input logic ld, input logic ill);
    return {ruwr, imm, a, b, br, alu, dmwr, dmc, src, ld, ill};
  endfunction

  function automatic logic [23:0] ctrl_a();
    return {ia.out_RUWr, ia.out_ImmSrc, ia.out_AluASrc, ia.out_AluBSrc, ia.out_BrOp,
            ia.out_ALUOp, ia.out_DMWr, ia.out_DMCtrl, ia.out_RUDataWrSrc, ia.out_is_load,
            ia.out_illegal};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_checks++; if (ia.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid_a got %b want 0", ia.out_valid); end
    n_checks++; if (ia.stall_count !== 2'd0) begin n_fail++; $display("FAIL reset_cnt_a got %0d want 0", ia.stall_count); end
    n_checks++; if (ctrl_a() !== 24'h0) begin n_fail++; $display("FAIL reset_ctrl_a got %h want 0", ctrl_a()); end
    n_checks++; if ({ia.out_pc, ia.out_rs1, ia.out_rs2, ia.out_rd} !== 47'h0) begin n_fail++; $display("FAIL reset_pc_idx_a got pc=%h rd=%0d want 0", ia.out_pc, ia.out_rd); end
    n_checks++; if (ib.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid_b got %b want 0", ib.out_valid); end
    rst = 1'b0;
  endtask

  task automatic test_add();
    ia.in_valid = 1'b1; ia.in_instr = I_ADD; ia.in_pc = 32'h100;
    #1;
    n_checks++; if (ia.in_ready !== 1'b1) begin n_fail++; $display("FAIL add_in_ready got %b want 1", ia.in_ready); end
    tick();
    ia.in_valid = 1'b0;
    n_checks++; if (ia.out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid got %b want 1", ia.out_valid); end
    n_checks++; if ({ia.out_RUWr, ia.out_ALUOp} !== 6'b1_00000) begin n_fail++; $display("FAIL add_ctrl got RUWr=%b ALUOp=%b want 1/00000", ia.out_RUWr, ia.out_ALUOp); end
    n_checks++; if ({ia.out_rs1, ia.out_rs2, ia.out_rd} !== {5'd1, 5'd2, 5'd3}) begin n_fail++; $display("FAIL add_idx got %0d,%0d,%0d want 1,2,3", ia.out_rs1, ia.out_rs2, ia.out_rd); end
    n_checks++; if (ia.out_pc !== 32'h100) begin n_fail++; $display("FAIL add_pc got %h want 100", ia.out_pc); end
    tick();
    n_checks++; if (ia.out_valid !== 1'b0) begin n_fail++; $display("FAIL add_drain got %b want 0", ia.out_valid); end
  endtask

  task automatic test_decode();
    logic [31:0] ins [21];
    logic [23:0] ex  [21];
    logic [23:0] msk [21];
    logic [23:0] full;
    logic [23:0] illm;
    logic [23:0] illv;
    full = 24'hFFFFFF;
    illm = mk(1, 3'b0, 0, 0, 5'h1F, 5'h0, 1, 3'b0, 2'b0, 0, 1);
    illv = mk(0, 3'b0, 0, 0, 5'h00, 5'h0, 0, 3'b0, 2'b0, 0, 1);
    ins[0]  = I_ADD;        ex[0]  = mk(1, 3'b000, 0, 0, 5'b00000, 5'b00000, 0, 3'b000, 2'b00, 0, 0); msk[0]  = full;
    ins[1]  = I_SUB;        ex[1]  = mk(1, 3'b000, 0, 0, 5'b00000, 5'b01000, 0, 3'b000, 2'b00, 0, 0); msk[1]  = full;
    ins[2]  = 32'h4020D1B3; ex[2]  = mk(1, 3'b000, 0, 0, 5'b00000, 5'b01101, 0, 3'b000, 2'b00, 0, 0); msk[2]  = full;
    ins[3]  = 32'h4020C1B3; ex[3]  = illv; msk[3]  = illm;
    ins[4]  = 32'hFFF08213; ex[4]  = mk(1, 3'b000, 0, 1, 5'b00000, 5'b00000, 0, 3'b000, 2'b00, 0, 0); msk[4]  = full;
    ins[5]  = 32'h4030D213; ex[5]  = mk(1, 3'b000, 0, 1, 5'b00000, 5'b01101, 0, 3'b000, 2'b00, 0, 0); msk[5]  = full;
    ins[6]  = 32'h40309213; ex[6]  = illv; msk[6]  = illm;
    ins[7]  = I_LW;         ex[7]  = mk(1, 3'b000, 0, 1, 5'b00000, 5'b00000, 0, 3'b010, 2'b01, 1, 0); msk[7]  = full;
    ins[8]  = 32'h00013303; ex[8]  = illv; msk[8]  = illm;
    ins[9]  = 32'h000100E7; ex[9]  = mk(1, 3'b000, 0, 1, 5'b10000, 5'b00000, 0, 3'b000, 2'b10, 0, 0); msk[9]  = full;
    ins[10] = 32'h00208063; ex[10] = mk(0, 3'b101, 1, 1, 5'b01000, 5'b00000, 0, 3'b000, 2'b00, 0, 0); msk[10] = full;
    ins[11] = 32'h0020C063; ex[11] = mk(0, 3'b101, 1, 1, 5'b01100, 5'b00000, 0, 3'b000, 2'b00, 0, 0); msk[11] = full;
    ins[12] = 32'h00002063; ex[12] = illv; msk[12] = illm;
    ins[13] = 32'h0020A023; ex[13] = mk(0, 3'b001, 0, 1, 5'b00000, 5'b00000, 1, 3'b010, 2'b00, 0, 0); msk[13] = full;
    ins[14] = 32'h0020B023; ex[14] = illv; msk[14] = illm;
    ins[15] = 32'h000000EF; ex[15] = mk(1, 3'b110, 1, 1, 5'b10000, 5'b00000, 0, 3'b000, 2'b10, 0, 0); msk[15] = full;
    ins[16] = 32'h123453B7; ex[16] = mk(1, 3'b010, 0, 1, 5'b00000, 5'b01001, 0, 3'b000, 2'b00, 0, 0); msk[16] = full;
    ins[17] = 32'h00001397; ex[17] = mk(1, 3'b010, 1, 1, 5'b00000, 5'b00000, 0, 3'b000, 2'b00, 0, 0); msk[17] = full;
    ins[18] = I_MUL;        ex[18] = mk(1, 3'b000, 0, 0, 5'b00000, 5'b10000, 0, 3'b000, 2'b00, 0, 0); msk[18] = full;
    ins[19] = 32'h0220D1B3; ex[19] = mk(1, 3'b000, 0, 0, 5'b00000, 5'b10101, 0, 3'b000, 2'b00, 0, 0); msk[19] = full;
    ins[20] = 32'h0000007F; ex[20] = illv; msk[20] = illm;
    for (int i = 0; i < 21; i++) begin
      ia.in_valid = 1'b1; ia.in_instr = ins[i]; ia.in_pc = 32'h1000 + 32'(4 * i);
      tick();
      n_checks++;
      if ((ctrl_a() & msk[i]) !== (ex[i] & msk[i]) || ia.out_valid !== 1'b1 || ia.out_pc !== 32'h1000 + 32'(4 * i)) begin
        n_fail++;
        $display("FAIL decode[%0d] instr=%h got ctrl=%h valid=%b pc=%h want ctrl=%h (mask %h) valid=1", i, ins[i], ctrl_a(), ia.out_valid, ia.out_pc, ex[i], msk[i]);
      end
    end
    ia.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_no_m();
    ib.in_valid = 1'b1; ib.in_instr = I_MUL; ib.in_pc = 32'h40;
    tick();
    ib.in_valid = 1'b0;
    n_checks++; if ({ib.out_valid, ib.out_illegal, ib.out_RUWr} !== 3'b110) begin n_fail++; $display("FAIL mul_no_m got valid=%b illegal=%b RUWr=%b want 1/1/0", ib.out_valid, ib.out_illegal, ib.out_RUWr); end
    tick();
  endtask

  task automatic test_hazard();
    n_checks++; if (ia.stall_count !== 2'd0) begin n_fail++; $display("FAIL hz_cnt_start got %0d want 0", ia.stall_count); end
    ia.in_valid = 1'b1; ia.in_instr = I_LW;
    tick();
    ia.in_instr = I_DEP;
    #1;
    n_checks++; if ({ia.hazard_stall, ia.in_ready} !== 2'b10) begin n_fail++; $display("FAIL hz_stall got stall=%b ready=%b want 1/0", ia.hazard_stall, ia.in_ready); end
    tick();
    n_checks++; if (ia.out_valid !== 1'b0) begin n_fail++; $display("FAIL hz_bubble got valid=%b want 0", ia.out_valid); end
    n_checks++; if (ia.stall_count !== 2'd1) begin n_fail++; $display("FAIL hz_cnt got %0d want 1", ia.stall_count); end
    n_checks++; if ({ia.hazard_stall, ia.in_ready} !== 2'b01) begin n_fail++; $display("FAIL hz_clear got stall=%b ready=%b want 0/1", ia.hazard_stall, ia.in_ready); end
    tick();
    ia.in_valid = 1'b0;
    n_checks++; if ({ia.out_valid, ia.out_rs1, ia.out_rd} !== {1'b1, 5'd5, 5'd6}) begin n_fail++; $display("FAIL hz_dep got valid=%b rs1=%0d rd=%0d want 1/5/6", ia.out_valid, ia.out_rs1, ia.out_rd); end
    tick();
  endtask

  task automatic test_no_hazard();
    ib.in_valid = 1'b1; ib.in_instr = I_LW;
    tick();
    ib.in_instr = I_DEP;
    #1;
    n_checks++; if ({ib.hazard_stall, ib.in_ready} !== 2'b01) begin n_fail++; $display("FAIL nohz_ready got stall=%b ready=%b want 0/1", ib.hazard_stall, ib.in_ready); end
    tick();
    ib.in_valid = 1'b0;
    n_checks++; if ({ib.out_valid, ib.out_rd, ib.stall_count} !== {1'b1, 5'd6, 16'd0}) begin n_fail++; $display("FAIL nohz_dep got valid=%b rd=%0d cnt=%0d want 1/6/0", ib.out_valid, ib.out_rd, ib.stall_count); end
    tick();
  endtask

  task automatic test_backpressure();
    ia.out_ready = 1'b0;
    ia.in_valid = 1'b1; ia.in_instr = I_ADD; ia.in_pc = 32'h200;
    tick();
    ia.in_instr = I_SUB; ia.in_pc = 32'h204;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (ia.in_ready !== 1'b0 || ia.out_valid !== 1'b1 || ia.out_pc !== 32'h200 || ia.out_ALUOp !== 5'b00000) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got ready=%b valid=%b pc=%h alu=%b want 0/1/200/00000", c, ia.in_ready, ia.out_valid, ia.out_pc, ia.out_ALUOp);
      end
      tick();
    end
    ia.out_ready = 1'b1;
    #1;
    n_checks++; if (ia.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got ready=%b want 1", ia.in_ready); end
    tick();
    ia.in_valid = 1'b0;
    n_checks++; if ({ia.out_valid, ia.out_pc, ia.out_ALUOp} !== {1'b1, 32'h204, 5'b01000}) begin n_fail++; $display("FAIL bp_next got valid=%b pc=%h alu=%b want 1/204/01000", ia.out_valid, ia.out_pc, ia.out_ALUOp); end
    tick();
  endtask

  task automatic test_flush_hazard();
    ia.in_valid = 1'b1; ia.in_instr = I_LW;
    tick();
    ia.in_instr = I_DEP; ia.flush = 1'b1;
    #1;
    n_checks++; if ({ia.hazard_stall, ia.in_ready} !== 2'b00) begin n_fail++; $display("FAIL fl_stall got stall=%b ready=%b want 0/0", ia.hazard_stall, ia.in_ready); end
    tick();
    ia.flush = 1'b0; ia.in_valid = 1'b0;
    n_checks++; if (ia.out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_empty got valid=%b want 0", ia.out_valid); end
    tick();
    n_checks++; if ({ia.out_valid, ia.stall_count} !== {1'b0, 2'd1}) begin n_fail++; $display("FAIL fl_nocap got valid=%b cnt=%0d want 0/1", ia.out_valid, ia.stall_count); end
  endtask

  task automatic test_rst_midstream();
    ia.in_valid = 1'b1; ia.in_instr = I_LW;
    tick();
    ia.in_instr = I_DEP;
    tick();
    n_checks++; if (ia.stall_count !== 2'd2) begin n_fail++; $display("FAIL rst_pre_cnt got %0d want 2", ia.stall_count); end
    tick();
    rst = 1'b1; ia.in_valid = 1'b0;
    n_checks++; if (ia.out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid got %b want 1", ia.out_valid); end
    tick();
    rst = 1'b0;
    n_checks++; if ({ia.out_valid, ia.stall_count, ia.out_rd} !== {1'b0, 2'd0, 5'd0}) begin n_fail++; $display("FAIL rst_mid got valid=%b cnt=%0d rd=%0d want 0/0/0", ia.out_valid, ia.stall_count, ia.out_rd); end
  endtask

  task automatic test_stall_saturate();
    logic [1:0] e;
    for (int k = 1; k <= 5; k++) begin
      ia.in_valid = 1'b1; ia.in_instr = I_LW;
      tick();
      ia.in_instr = I_DEP;
      tick();
      tick();
      e = (k < 3) ? 2'(k) : 2'd3;
      n_checks++; if (ia.stall_count !== e) begin n_fail++; $display("FAIL sat_cnt[%0d] got %0d want %0d", k, ia.stall_count, e); end
    end
    ia.in_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    ia.in_valid = 1'b0; ia.in_instr = 32'h0; ia.in_pc = 32'h0; ia.flush = 1'b0; ia.out_ready = 1'b1;
    ib.in_valid = 1'b0; ib.in_instr = 32'h0; ib.in_pc = 32'h0; ib.flush = 1'b0; ib.out_ready = 1'b1;
    test_reset();
    test_add();
    test_decode();
    test_no_m();
    test_hazard();
    test_no_hazard();
    test_backpressure();
    test_flush_hazard();
    test_rst_midstream();
    test_stall_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
